// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, freeze, flush,
// optional 2-entry skid buffer and a saturating freeze-cycle counter.
module pipe_stage_buf #(
    parameter int unsigned       WIDTH     = 64,
    parameter int unsigned       SKID      = 1,
    parameter logic [WIDTH-1:0]  FLUSH_VAL = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam bit               HAS_SKID = (SKID != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             main_v_q, main_v_d;
    logic [WIDTH-1:0] main_d_q, main_d_d;
    logic             skid_v_q, skid_v_d;
    logic [WIDTH-1:0] skid_d_q, skid_d_d;
    logic [CNT_W-1:0] stall_q,  stall_d;
    logic             push, pop;

    // With a skid entry, ready depends only on local state; otherwise it follows out_ready.
    assign in_ready  = (HAS_SKID ? !skid_v_q : (!main_v_q || out_ready)) && !freeze && !flush;
    assign out_valid = main_v_q && !freeze && !flush;
    assign out_data  = main_d_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign stall_cnt = stall_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        main_v_d = main_v_q;
        main_d_d = main_d_q;
        skid_v_d = skid_v_q;
        skid_d_d = skid_d_q;
        stall_d  = stall_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d_d = FLUSH_VAL;
        end else if (freeze) begin
            if (stall_q != CNT_MAX) begin
                stall_d = stall_q + CNT_W'(1);
            end
        end else if (HAS_SKID) begin
            // FIFO order is main then skid; skid refills main on every pop.
            if (pop && skid_v_q) begin
                main_d_d = skid_d_q;
                skid_v_d = push;
                if (push) begin
                    skid_d_d = in_data;
                end
            end else if (pop) begin
                main_v_d = push;
                if (push) begin
                    main_d_d = in_data;
                end
            end else if (push) begin
                if (!main_v_q) begin
                    main_v_d = 1'b1;
                    main_d_d = in_data;
                end else begin
                    skid_v_d = 1'b1;
                    skid_d_d = in_data;
                end
            end
        end else begin
            if (push) begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end else if (pop) begin
                main_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_v_q <= 1'b0;
            main_d_q <= FLUSH_VAL;
            skid_v_q <= 1'b0;
            skid_d_q <= '0;
            stall_q  <= '0;
        end else begin
            main_v_q <= main_v_d;
            main_d_q <= main_d_d;
            skid_v_q <= skid_v_d;
            skid_d_q <= skid_d_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one skid instance and one single-entry instance,
// directed vector table, hand sequences and queue-model random checking.
module tb_pipe_stage_buf;

    localparam logic [63:0] NFLUSH = 64'hDEAD_BEEF_0BAD_F00D;

    logic clk, rst;

    logic        s_fl, s_fr, s_iv, s_or, s_ir, s_ov;
    logic [63:0] s_d, s_od;
    logic [1:0]  s_occ;
    logic [15:0] s_st;

    logic        n_fl, n_fr, n_iv, n_or, n_ir, n_ov;
    logic [63:0] n_d, n_od;
    logic [1:0]  n_occ;
    logic [2:0]  n_st;

    pipe_stage_buf #(.WIDTH(64), .SKID(1), .FLUSH_VAL(64'h0), .CNT_W(16)) dut_s (
        .clk(clk), .rst(rst), .flush(s_fl), .freeze(s_fr),
        .in_valid(s_iv), .in_data(s_d), .in_ready(s_ir),
        .out_valid(s_ov), .out_data(s_od), .out_ready(s_or),
        .occupancy(s_occ), .stall_cnt(s_st)
    );

    pipe_stage_buf #(.WIDTH(64), .SKID(0), .FLUSH_VAL(NFLUSH), .CNT_W(3)) dut_n (
        .clk(clk), .rst(rst), .flush(n_fl), .freeze(n_fr),
        .in_valid(n_iv), .in_data(n_d), .in_ready(n_ir),
        .out_valid(n_ov), .out_data(n_od), .out_ready(n_or),
        .occupancy(n_occ), .stall_cnt(n_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        fl, fr, iv;
        logic [63:0] d;
        logic        orr;
        logic        ov;
        logic [63:0] od;
        logic        ir;
        logic [1:0]  occ;
        logic [15:0] st;
    } vec_t;

    function automatic vec_t mk(input logic fl, fr, iv, input logic [63:0] d, input logic orr,
                                input logic ov, input logic [63:0] od, input logic ir,
                                input logic [1:0] occ, input logic [15:0] st);
        vec_t v;
        v.fl = fl; v.fr = fr; v.iv = iv; v.d = d; v.orr = orr;
        v.ov = ov; v.od = od; v.ir = ir; v.occ = occ; v.st = st;
        return v;
    endfunction

    task automatic napply(input logic fl, fr, iv, input logic [63:0] d, input logic orr);
        @(posedge clk);
        #1;
        n_fl = fl; n_fr = fr; n_iv = iv; n_d = d; n_or = orr;
        @(negedge clk);
    endtask

    // Reference models: payload FIFO plus the value currently shown on out_data.
    logic [63:0] ms_q[$];
    logic [63:0] mn_q[$];
    logic [63:0] ms_md, mn_md;
    int          ms_st, mn_st;

    vec_t tbl[22];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] A, B, C, D, E, F, A7, B8, C9;
        int          n_words, cyc;
        logic        e_ov, e_ir;

        A  = 64'hAAAA_0000_0000_00A1; B  = 64'hBBBB_0000_0000_00B2;
        C  = 64'hCCCC_0000_0000_00C3; D  = 64'h1111_2222_3333_00D4;
        E  = 64'h4444_5555_6666_00E5; F  = 64'h7777_8888_9999_00F6;
        A7 = 64'h0123_4567_89AB_00A7; B8 = 64'hFEDC_BA98_7654_00B8;
        C9 = 64'h5A5A_A5A5_5A5A_00C9;

        // fl fr iv d orr | ov od ir occ st
        tbl[0]  = mk(0,0,1,A,0,  0,0,1,0,0);
        tbl[1]  = mk(0,0,1,B,0,  1,A,1,1,0);
        tbl[2]  = mk(0,0,1,C,0,  1,A,0,2,0);
        tbl[3]  = mk(0,0,1,C,0,  1,A,0,2,0);
        tbl[4]  = mk(0,0,1,C,1,  1,A,0,2,0);
        tbl[5]  = mk(0,0,1,C,1,  1,B,1,1,0);
        tbl[6]  = mk(0,0,0,0,1,  1,C,1,1,0);
        tbl[7]  = mk(0,0,0,0,1,  0,C,1,0,0);
        tbl[8]  = mk(0,0,1,D,0,  0,C,1,0,0);
        tbl[9]  = mk(0,0,1,E,0,  1,D,1,1,0);
        for (int k = 0; k < 5; k++) tbl[10+k] = mk(0,1,1,F,1, 0,D,0,2,16'(k));
        tbl[15] = mk(0,0,0,0,1,  1,D,0,2,5);
        tbl[16] = mk(0,0,0,0,1,  1,E,1,1,5);
        tbl[17] = mk(0,0,0,0,0,  0,E,1,0,5);
        tbl[18] = mk(0,0,1,A7,0, 0,E,1,0,5);
        tbl[19] = mk(0,0,1,B8,0, 1,A7,1,1,5);
        tbl[20] = mk(1,1,1,C9,1, 0,A7,0,2,5);
        tbl[21] = mk(0,0,0,0,0,  0,0,1,0,5);

        rst = 1'b0;
        s_fl = 0; s_fr = 0; s_iv = 0; s_d = '0; s_or = 0;
        n_fl = 0; n_fr = 0; n_iv = 0; n_d = '0; n_or = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_s_ov",  64'(s_ov),  0);
        chk("rst_s_od",  s_od,       0);
        chk("rst_s_occ", 64'(s_occ), 0);
        chk("rst_s_st",  64'(s_st),  0);
        chk("rst_s_ir",  64'(s_ir),  1);
        chk("rst_n_ov",  64'(n_ov),  0);
        chk("rst_n_od",  n_od,       NFLUSH);
        chk("rst_n_occ", 64'(n_occ), 0);
        chk("rst_n_st",  64'(n_st),  0);
        chk("rst_n_ir",  64'(n_ir),  1);

        // Skid instance: back-pressure, freeze and flush corner vectors.
        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            s_fl = tbl[i].fl; s_fr = tbl[i].fr; s_iv = tbl[i].iv; s_d = tbl[i].d; s_or = tbl[i].orr;
            @(negedge clk);
            chk($sformatf("tbl%0d_ov", i),  64'(s_ov),  64'(tbl[i].ov));
            chk($sformatf("tbl%0d_od", i),  s_od,       tbl[i].od);
            chk($sformatf("tbl%0d_ir", i),  64'(s_ir),  64'(tbl[i].ir));
            chk($sformatf("tbl%0d_occ", i), 64'(s_occ), 64'(tbl[i].occ));
            chk($sformatf("tbl%0d_st", i),  64'(s_st),  64'(tbl[i].st));
        end

        // Streaming: one word per cycle with one cycle of latency.
        for (int k = 0; k <= 100; k++) begin
            @(posedge clk);
            #1;
            s_fl = 0; s_fr = 0; s_or = 1;
            s_iv = (k < 100);
            s_d  = 64'h1000 + 64'(k);
            @(negedge clk);
            if (k == 0) begin
                chk("stream_ov0", 64'(s_ov), 0);
            end else begin
                chk($sformatf("stream_ov%0d", k), 64'(s_ov), 1);
                chk($sformatf("stream_od%0d", k), s_od, 64'h1000 + 64'(k - 1));
            end
            if (k < 100) chk($sformatf("stream_ir%0d", k), 64'(s_ir), 1);
        end
        @(posedge clk);
        #1 s_iv = 0; s_or = 0;

        // Single-entry instance: counter saturation, full stall, flush value.
        for (int c = 0; c < 10; c++) begin
            napply(0, 1, 0, 0, 0);
            chk($sformatf("sat_st%0d", c), 64'(n_st), 64'((c < 7) ? c : 7));
            chk($sformatf("sat_ir%0d", c), 64'(n_ir), 0);
        end
        napply(0, 0, 0, 0, 0);
        chk("sat_final", 64'(n_st), 7);
        napply(0, 0, 1, 64'h55, 0);
        chk("n_push_ir", 64'(n_ir), 1);
        napply(0, 0, 1, 64'h66, 0);
        chk("n_full_ov", 64'(n_ov), 1);
        chk("n_full_od", n_od, 64'h55);
        chk("n_full_ir", 64'(n_ir), 0);
        napply(0, 0, 1, 64'h66, 1);
        chk("n_thru_ir", 64'(n_ir), 1);
        chk("n_thru_od", n_od, 64'h55);
        napply(1, 0, 0, 0, 1);
        chk("n_fl_ov", 64'(n_ov), 0);
        chk("n_fl_od", n_od, 64'h66);
        napply(0, 0, 0, 0, 0);
        chk("n_post_fl_od",  n_od, NFLUSH);
        chk("n_post_fl_occ", 64'(n_occ), 0);
        chk("n_post_fl_st",  64'(n_st), 7);

        // Random phase on both instances against the queue models.
        @(posedge clk);
        #1 rst = 1'b0;
        s_fl = 0; s_fr = 0; s_iv = 0; s_or = 0;
        n_fl = 0; n_fr = 0; n_iv = 0; n_or = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        ms_q.delete(); mn_q.delete();
        ms_md = '0; mn_md = NFLUSH; ms_st = 0; mn_st = 0;
        n_words = 0;
        cyc = 0;
        while (n_words < 1000 && cyc < 10000) begin
            @(posedge clk);
            #1;
            s_fl = ($urandom_range(59) == 0); s_fr = ($urandom_range(9) == 0);
            s_iv = ($urandom_range(9) < 7);   s_or = $urandom_range(1);
            s_d  = {$urandom, $urandom};
            n_fl = ($urandom_range(59) == 0); n_fr = ($urandom_range(9) == 0);
            n_iv = ($urandom_range(9) < 7);   n_or = $urandom_range(1);
            n_d  = {$urandom, $urandom};
            @(negedge clk);

            e_ov = (ms_q.size() > 0) && !s_fr && !s_fl;
            e_ir = (ms_q.size() < 2) && !s_fr && !s_fl;
            chk("rnd_s_ov",  64'(s_ov),  64'(e_ov));
            chk("rnd_s_ir",  64'(s_ir),  64'(e_ir));
            chk("rnd_s_od",  s_od,       ms_md);
            chk("rnd_s_occ", 64'(s_occ), 64'(ms_q.size()));
            chk("rnd_s_st",  64'(s_st),  64'(ms_st));
            if (s_fl) begin
                ms_q.delete();
                ms_md = '0;
            end else if (s_fr) begin
                if (ms_st < 65535) ms_st++;
            end else begin
                if (e_ov && s_or) ms_md = ms_q.pop_front();
                if (s_iv && e_ir) ms_q.push_back(s_d);
                if (ms_q.size() > 0) ms_md = ms_q[0];
            end

            e_ov = (mn_q.size() > 0) && !n_fr && !n_fl;
            e_ir = (mn_q.size() == 0 || n_or) && !n_fr && !n_fl;
            chk("rnd_n_ov",  64'(n_ov),  64'(e_ov));
            chk("rnd_n_ir",  64'(n_ir),  64'(e_ir));
            chk("rnd_n_od",  n_od,       mn_md);
            chk("rnd_n_occ", 64'(n_occ), 64'(mn_q.size()));
            chk("rnd_n_st",  64'(n_st),  64'(mn_st));
            if (n_fl) begin
                mn_q.delete();
                mn_md = NFLUSH;
            end else if (n_fr) begin
                if (mn_st < 7) mn_st++;
            end else begin
                if (e_ov && n_or) begin
                    mn_md = mn_q.pop_front();
                    n_words++;
                end
                if (n_iv && e_ir) mn_q.push_back(n_d);
                if (mn_q.size() > 0) mn_md = mn_q[0];
            end
            cyc++;
        end
        chk("rnd_words_delivered", 64'(n_words >= 1000), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
